// File: rtl/usb_bus_master_arb.sv
// Round-robin master for the SiLibUSB 8-bit bus: normal cycle is 1+STROBE_CYC+HOLD_CYC+1 cycles to ACK, fast read is 3.
// No backpressure: REQ is held by the requester until its one-cycle ACK, and only the IDLE state accepts a new grant.
module usb_bus_master_arb #(
  parameter logic [15:0] ADDR_OFFSET = 16'h4000,
  parameter int          STROBE_CYC  = 2,
  parameter int          HOLD_CYC    = 1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic [1:0]  REQ,
  input  logic [1:0]  REQ_WR,
  input  logic [1:0]  REQ_FAST,
  input  logic [31:0] REQ_ADD,
  input  logic [15:0] REQ_WDATA,
  output logic [1:0]  ACK,
  output logic [7:0]  RDATA,
  output logic        BUSY,
  output logic        RD_B,
  output logic        WR_B,
  output logic [15:0] ADD,
  output logic [7:0]  DATA_O,
  output logic        DATA_OE,
  input  logic [7:0]  DATA_I,
  output logic        FREAD,
  output logic        FSTROBE,
  output logic        FMODE,
  input  logic [7:0]  FD
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_F0     = 3'd4;
  localparam logic [2:0] ST_F1     = 3'd5;
  localparam logic [2:0] ST_ACK    = 3'd6;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        pri_q, pri_d;
  logic        wr_q, wr_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_b_q, rd_b_d;
  logic        wr_b_q, wr_b_d;
  logic [15:0] add_q, add_d;
  logic [7:0]  data_o_q, data_o_d;
  logic        data_oe_q, data_oe_d;
  logic        fread_q, fread_d;
  logic        fstrobe_q, fstrobe_d;
  logic        fmode_q, fmode_d;

  logic        sel;
  logic [15:0] sel_add;
  logic [7:0]  sel_wdata;

  // On a tie the pointer names the port that was not served last.
  always_comb begin
    sel = 1'b0;
    if (REQ == 2'b11) begin
      sel = pri_q;
    end else begin
      sel = REQ[1];
    end
    sel_add   = sel ? REQ_ADD[31:16]  : REQ_ADD[15:0];
    sel_wdata = sel ? REQ_WDATA[15:8] : REQ_WDATA[7:0];
  end

  // Output registers are loaded from the state being entered, so every
  // bus pin is a clean flop output aligned with its state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    pri_d     = pri_q;
    wr_d      = wr_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    rd_b_d    = 1'b1;
    wr_b_d    = 1'b1;
    add_d     = add_q;
    data_o_d  = data_o_q;
    data_oe_d = data_oe_q;
    fread_d   = 1'b0;
    fstrobe_d = 1'b0;
    fmode_d   = fmode_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          gnt_d = sel;
          wr_d  = REQ_WR[sel];
          if (REQ_FAST[sel]) begin
            state_d   = ST_F0;
            fread_d   = 1'b1;
            fstrobe_d = 1'b1;
            fmode_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
            add_d   = sel_add + ADDR_OFFSET;
            if (REQ_WR[sel]) begin
              data_o_d  = sel_wdata;
              data_oe_d = 1'b1;
            end
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LOAD;
        if (wr_q) begin
          wr_b_d = 1'b0;
        end else begin
          rd_b_d = 1'b0;
        end
      end

      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          if (!wr_q) begin
            rdata_d = DATA_I;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (wr_q) begin
            wr_b_d = 1'b0;
          end else begin
            rd_b_d = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_ACK;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          add_d     = 16'h0000;
          data_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_F0: begin
        state_d = ST_F1;
      end

      // FMODE stays up through the ACK cycle so it frames the whole fast transfer.
      ST_F1: begin
        state_d = ST_ACK;
        rdata_d = FD;
        ack_d   = gnt_q ? 2'b10 : 2'b01;
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        pri_d   = ~gnt_q;
        fmode_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        add_d     = 16'h0000;
        data_oe_d = 1'b0;
        fmode_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= 1'b0;
      pri_q     <= 1'b0;
      wr_q      <= 1'b0;
      ack_q     <= 2'b00;
      rdata_q   <= 8'h00;
      rd_b_q    <= 1'b1;
      wr_b_q    <= 1'b1;
      add_q     <= 16'h0000;
      data_o_q  <= 8'h00;
      data_oe_q <= 1'b0;
      fread_q   <= 1'b0;
      fstrobe_q <= 1'b0;
      fmode_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      pri_q     <= pri_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rd_b_q    <= rd_b_d;
      wr_b_q    <= wr_b_d;
      add_q     <= add_d;
      data_o_q  <= data_o_d;
      data_oe_q <= data_oe_d;
      fread_q   <= fread_d;
      fstrobe_q <= fstrobe_d;
      fmode_q   <= fmode_d;
    end
  end

  assign ACK     = ack_q;
  assign RDATA   = rdata_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign RD_B    = rd_b_q;
  assign WR_B    = wr_b_q;
  assign ADD     = add_q;
  assign DATA_O  = data_o_q;
  assign DATA_OE = data_oe_q;
  assign FREAD   = fread_q;
  assign FSTROBE = fstrobe_q;
  assign FMODE   = fmode_q;

endmodule

// File: tb/tb_usb_bus_master_arb.sv
// Directed bench for usb_bus_master_arb with default parameters.
module tb_usb_bus_master_arb;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic [1:0]  REQ, REQ_WR, REQ_FAST;
  logic [31:0] REQ_ADD;
  logic [15:0] REQ_WDATA;
  logic [1:0]  ACK;
  logic [7:0]  RDATA;
  logic        BUSY, RD_B, WR_B;
  logic [15:0] ADD;
  logic [7:0]  DATA_O;
  logic        DATA_OE;
  logic [7:0]  DATA_I;
  logic        FREAD, FSTROBE, FMODE;
  logic [7:0]  FD;

  usb_bus_master_arb dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .REQ(REQ), .REQ_WR(REQ_WR),
    .REQ_FAST(REQ_FAST), .REQ_ADD(REQ_ADD), .REQ_WDATA(REQ_WDATA),
    .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .RD_B(RD_B), .WR_B(WR_B),
    .ADD(ADD), .DATA_O(DATA_O), .DATA_OE(DATA_OE), .DATA_I(DATA_I),
    .FREAD(FREAD), .FSTROBE(FSTROBE), .FMODE(FMODE), .FD(FD)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int          n_cyc, add_cyc, wr_lo, rd_lo, oe_cyc, frd_cyc, fst_cyc, fm_cyc;
  int          bad_both, bad_oe;
  logic        ack_seen;
  logic [1:0]  ack_val;
  logic [7:0]  rdata_ack, dout_first;
  logic [15:0] add_first;

  // One transfer; DATA_I/FD carry the payload only while the DUT should sample it.
  task automatic xfer(input int port, input logic wr, input logic fast,
                      input logic [15:0] addr, input logic [7:0] wd,
                      input logic [7:0] din, input logic [7:0] fdv,
                      input logic [15:0] exp_add);
    @(negedge BUS_CLK);
    REQ = 2'b00; REQ_WR = 2'b00; REQ_FAST = 2'b00;
    REQ[port] = 1'b1; REQ_WR[port] = wr; REQ_FAST[port] = fast;
    if (port == 1) begin
      REQ_ADD[31:16] = addr; REQ_WDATA[15:8] = wd;
    end else begin
      REQ_ADD[15:0] = addr; REQ_WDATA[7:0] = wd;
    end
    DATA_I = 8'h00; FD = 8'h00;
    n_cyc = 0; add_cyc = 0; wr_lo = 0; rd_lo = 0; oe_cyc = 0;
    frd_cyc = 0; fst_cyc = 0; fm_cyc = 0; bad_oe = 0;
    ack_seen = 1'b0; ack_val = 2'b00; rdata_ack = 8'h00;
    add_first = 16'hxxxx; dout_first = 8'hxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge BUS_CLK);
      n_cyc++;
      if (n_cyc == 1) begin
        add_first = ADD; dout_first = DATA_O;
      end
      if (ADD == exp_add) add_cyc++;
      if (!WR_B) wr_lo++;
      if (!RD_B) rd_lo++;
      if (DATA_OE) oe_cyc++;
      if (FREAD) frd_cyc++;
      if (FSTROBE) fst_cyc++;
      if (FMODE) fm_cyc++;
      if (!RD_B && !WR_B) bad_both++;
      if (DATA_OE && (!wr || fast)) bad_oe++;
      DATA_I = (!RD_B) ? din : 8'h00;
      FD     = (FMODE && !FREAD) ? fdv : 8'h00;
      if (ACK != 2'b00) begin
        ack_seen = 1'b1; ack_val = ACK; rdata_ack = RDATA;
        REQ = 2'b00;
        break;
      end
    end
    REQ = 2'b00;
  endtask

  // Holds REQ=11 (reads) until nx ACKs, checking alternation and idle gaps.
  task automatic rr_run(input int nx, input int first, input string tag);
    int k, idle;
    @(negedge BUS_CLK);
    REQ = 2'b11; REQ_WR = 2'b00; REQ_FAST = 2'b00;
    REQ_ADD = 32'h0022_0011; DATA_I = 8'h00;
    k = 0; idle = 0;
    for (int i = 0; i < 80 && k < nx; i++) begin
      @(negedge BUS_CLK);
      if (!BUSY) idle++;
      if (!RD_B && !WR_B) bad_both++;
      if (ACK != 2'b00) begin
        chk($sformatf("%s_port%0d", tag, k), {30'd0, ACK}, ((k + first) % 2 == 1) ? 32'd2 : 32'd1);
        if (k > 0) chk($sformatf("%s_gap%0d", tag, k), (idle >= 1) ? 32'd1 : 32'd0, 32'd1);
        idle = 0;
        k++;
        if (k == nx) REQ = 2'b00;
      end
    end
    REQ = 2'b00;
    chk({tag, "_count"}, k, nx);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_b"}, RD_B, 1);
    chk({tag, "_wr_b"}, WR_B, 1);
    chk({tag, "_add"}, ADD, 0);
    chk({tag, "_data_o"}, DATA_O, 0);
    chk({tag, "_data_oe"}, DATA_OE, 0);
    chk({tag, "_fread"}, FREAD, 0);
    chk({tag, "_fstrobe"}, FSTROBE, 0);
    chk({tag, "_fmode"}, FMODE, 0);
    chk({tag, "_ack"}, ACK, 0);
    chk({tag, "_rdata"}, RDATA, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    BUS_RST = 1'b1; REQ = 2'b00; REQ_WR = 2'b00; REQ_FAST = 2'b00;
    REQ_ADD = 32'd0; REQ_WDATA = 16'd0; DATA_I = 8'h00; FD = 8'h00;
    bad_both = 0;
    repeat (3) @(negedge BUS_CLK);
    check_reset_vals("rst");
    BUS_RST = 1'b0;

    // Port 0 write 0x0010 <- 0xA5
    xfer(0, 1'b1, 1'b0, 16'h0010, 8'hA5, 8'h00, 8'h00, 16'h4010);
    chk("wr_ack_seen", ack_seen, 1);
    chk("wr_latency", n_cyc, 5);
    chk("wr_ack", ack_val, 2'b01);
    chk("wr_add_cycles", add_cyc, 4);
    chk("wr_wrb_low", wr_lo, 2);
    chk("wr_rdb_low", rd_lo, 0);
    chk("wr_oe_cycles", oe_cyc, 4);
    chk("wr_data_o", dout_first, 8'hA5);

    // Port 1 read 0x0003, DATA_I = 0x3C while RD_B low
    xfer(1, 1'b0, 1'b0, 16'h0003, 8'h00, 8'h3C, 8'h00, 16'h4003);
    chk("rd_latency", n_cyc, 5);
    chk("rd_ack", ack_val, 2'b10);
    chk("rd_rdb_low", rd_lo, 2);
    chk("rd_wrb_low", wr_lo, 0);
    chk("rd_rdata", rdata_ack, 8'h3C);
    chk("rd_oe_cycles", oe_cyc, 0);
    chk("rd_add_cycles", add_cyc, 4);

    // Port 0 read at 0xC000 wraps to 0x0000
    xfer(0, 1'b0, 1'b0, 16'hC000, 8'h00, 8'h5A, 8'h00, 16'h0000);
    chk("wrap_add", add_first, 16'h0000);
    chk("wrap_rdata", rdata_ack, 8'h5A);
    chk("wrap_ack", ack_val, 2'b01);

    // Port 1 fast read, FD = 0x7E
    xfer(1, 1'b1, 1'b1, 16'h0000, 8'h00, 8'h00, 8'h7E, 16'h0000);
    chk("fast_latency", n_cyc, 3);
    chk("fast_ack", ack_val, 2'b10);
    chk("fast_fread", frd_cyc, 1);
    chk("fast_fstrobe", fst_cyc, 1);
    chk("fast_fmode", fm_cyc, 3);
    chk("fast_rdata", rdata_ack, 8'h7E);
    chk("fast_no_strobe", rd_lo + wr_lo, 0);
    chk("fast_oe", oe_cyc, 0);

    // Both requesting: last grant was port 1, so 0,1,0,1
    rr_run(4, 0, "rr");

    // Reset in second strobe cycle of a port 0 write
    @(negedge BUS_CLK);
    REQ = 2'b01; REQ_WR = 2'b01; REQ_FAST = 2'b00;
    REQ_ADD[15:0] = 16'h0055; REQ_WDATA[7:0] = 8'h33;
    repeat (3) @(negedge BUS_CLK);
    chk("mid_wrb_low_before", WR_B, 0);
    BUS_RST = 1'b1; REQ = 2'b00;
    @(negedge BUS_CLK);
    check_reset_vals("mid");
    BUS_RST = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge BUS_CLK);
      if (ACK != 2'b00) ack_seen = 1'b1;
    end
    chk("mid_no_ack", ack_seen, 0);

    // Pointer restarts at port 0 after reset
    rr_run(1, 0, "rr_after_rst");

    chk("never_both_strobes", bad_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
